// File: rtl/t07_memory_responder.sv
// Responder for the CPU one-cycle rwi request protocol: runs each fetch/load/store as a single
// Wishbone-classic access, reports completion via the falling edge of busy plus a result pulse.
module t07_memory_responder #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic        busy,
  output logic [31:0] rdata_o,
  output logic [31:0] instr_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpFetch = 2'b11;
  // Abort fires on the REQ cycle whose count equals this, so busy stays high TIMEOUT cycles.
  localparam logic [7:0] LastCnt = TIMEOUT - 8'd1;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] lat_adr_q, lat_adr_d;
  logic [31:0] lat_wdat_q, lat_wdat_d;
  logic [3:0]  lat_sel_q, lat_sel_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] instr_q, instr_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  logic ack_hit;
  logic timeout_hit;

  assign ack_hit     = (state_q == StReq) && ack_i;
  assign timeout_hit = (state_q == StReq) && !ack_i && (cnt_q == LastCnt);

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      lat_adr_q  <= '0;
      lat_wdat_q <= '0;
      lat_sel_q  <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      instr_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lat_adr_q  <= lat_adr_d;
      lat_wdat_q <= lat_wdat_d;
      lat_sel_q  <= lat_sel_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      instr_q    <= instr_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lat_adr_d  = lat_adr_q;
    lat_wdat_d = lat_wdat_q;
    lat_sel_d  = lat_sel_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (rwi != 2'b00) begin
          state_d    = StReq;
          op_d       = rwi;
          lat_adr_d  = addr_i;
          lat_wdat_d = wdata_i;
          lat_sel_d  = sel_i;
          cnt_d      = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StReq: begin
        // rwi is deliberately ignored here: one access in flight, no queueing.
        if (ack_i || (cnt_q == LastCnt)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: bus outputs follow the next state so they appear with the REQ entry edge.
  always_comb begin
    req_d    = (state_d == StReq);
    we_d     = req_d && (op_d == OpWrite);
    adr_d    = req_d ? lat_adr_d : 32'h0;
    dat_d    = we_d ? lat_wdat_d : 32'h0;
    sel_d    = we_d ? lat_sel_d : (req_d ? 4'hF : 4'h0);
    rvalid_d = ack_hit;
    err_d    = timeout_hit;
    rdata_d  = (ack_hit && (op_q == OpLoad)) ? dat_i : rdata_q;
    instr_d  = (ack_hit && (op_q == OpFetch)) ? dat_i : instr_q;
  end

  assign busy     = req_q;
  assign cyc_o    = req_q;
  assign stb_o    = req_q;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign sel_o    = sel_q;
  assign rdata_o  = rdata_q;
  assign instr_o  = instr_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule
